// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, pipeline-stage records and compare helpers for the MIPS hazard controller.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_W     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;
    localparam logic [1:0] FWD_E     = 2'd3;
    localparam logic [1:0] TUSE_NONE = 2'b11;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md_start;
        logic       md_div;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
    } m_stage_t;

    // A producer still in flight blocks a D-stage reader when its result is later than the reader's need.
    function automatic logic data_stall(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                        input logic [4:0] m_a3, input logic [1:0] m_tnew);
        logic hit_e;
        logic hit_m;
        hit_e = (e_a3 == src) && (e_tnew > tuse);
        hit_m = (m_a3 == src) && (m_tnew > tuse);
        return (tuse != TUSE_NONE) && (src != 5'd0) && (hit_e || hit_m);
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic [4:0] src,
                                             input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                             input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                             input logic [4:0] w_a3);
        if (src == 5'd0)                          return FWD_RF;
        else if (e_a3 == src && e_tnew == 2'd0)   return FWD_E;
        else if (m_a3 == src && m_tnew == 2'd0)   return FWD_M;
        else if (w_a3 == src)                     return FWD_W;
        else                                      return FWD_RF;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] src,
                                             input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                             input logic [4:0] w_a3);
        if (src == 5'd0)                          return FWD_RF;
        else if (m_a3 == src && m_tnew == 2'd0)   return FWD_M;
        else if (w_a3 == src)                     return FWD_W;
        else                                      return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder <-> hazard controller bundle: D-stage hazard info in, stall and forward selects out.
interface hazard_ctrl_if;

    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_Tuse_rs;
    logic [1:0] D_Tuse_rt;
    logic [4:0] D_A3;
    logic [1:0] D_Tnew;
    logic       D_md_start;
    logic       D_md_div;
    logic       D_md_use;

    logic       stall;
    logic       E_bubble;
    logic [1:0] fwd_D_rs;
    logic [1:0] fwd_D_rt;
    logic [1:0] fwd_E_rs;
    logic [1:0] fwd_E_rt;
    logic       md_busy;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew, D_md_start, D_md_div, D_md_use,
        input  stall, E_bubble, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, md_busy
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew, D_md_start, D_md_div, D_md_use,
        output stall, E_bubble, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, md_busy
    );

endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Mult/div busy down-counter: loads the op latency when the op enters M, busy while nonzero.
module md_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // A start while still counting is normally prevented by the stall; if it happens, reload.
    always_comb begin
        count_d = count_q;
        if (start)
            count_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (count_q != '0)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: shadow E/M/W tracking, stall/bubble and forward selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);

    e_stage_t   e_q, e_d;
    m_stage_t   m_q, m_d;
    logic [4:0] w_a3_q, w_a3_d;

    logic rs_stall;
    logic rt_stall;
    logic md_stall;
    logic stall;
    logic md_busy;

    assign rs_stall = data_stall(hz.D_rs, hz.D_Tuse_rs, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);
    assign rt_stall = data_stall(hz.D_rt, hz.D_Tuse_rt, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);
    assign md_stall = hz.D_md_use & (md_busy | e_q.md_start | m_q.md_start);
    assign stall    = rs_stall | rt_stall | md_stall;

    // A stalled D instruction stays put, so E receives an all-zero bubble instead.
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.a3       = hz.D_A3;
            e_d.tnew     = hz.D_Tnew;
            e_d.rs       = hz.D_rs;
            e_d.rt       = hz.D_rt;
            e_d.md_start = hz.D_md_start;
            e_d.md_div   = hz.D_md_div;
        end
    end

    always_comb begin
        m_d          = '0;
        m_d.a3       = e_q.a3;
        m_d.tnew     = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
        m_d.md_start = e_q.md_start;
        m_d.md_div   = e_q.md_div;
    end

    assign w_a3_d = m_q.a3;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_a3_q <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_a3_q <= w_a3_d;
        end
    end

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (m_q.md_start),
        .is_div (m_q.md_div),
        .busy   (md_busy)
    );

    assign hz.stall    = stall;
    assign hz.E_bubble = stall;
    assign hz.md_busy  = md_busy;
    assign hz.fwd_D_rs = fwd_d_sel(hz.D_rs, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_a3_q);
    assign hz.fwd_D_rt = fwd_d_sel(hz.D_rt, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_a3_q);
    assign hz.fwd_E_rs = fwd_e_sel(e_q.rs, m_q.a3, m_q.tnew, w_a3_q);
    assign hz.fwd_E_rt = fwd_e_sel(e_q.rt, m_q.a3, m_q.tnew, w_a3_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: load-use, branch, jal/jr, $0, rt hazards, priority, mult/div, reset.
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_ctrl_if hz ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                         input logic [4:0] a3, input logic [1:0] tnew,
                         input logic md_start, input logic md_div, input logic md_use);
        hz.D_rs       = rs;
        hz.D_rt       = rt;
        hz.D_Tuse_rs  = tuse_rs;
        hz.D_Tuse_rt  = tuse_rt;
        hz.D_A3       = a3;
        hz.D_Tnew     = tnew;
        hz.D_md_start = md_start;
        hz.D_md_div   = md_div;
        hz.D_md_use   = md_use;
        #1;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        nop();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        checks++;
        if ({hz.stall, hz.E_bubble, hz.md_busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000", {hz.stall, hz.E_bubble, hz.md_busy});
        end
        checks++;
        if ({hz.fwd_D_rs, hz.fwd_D_rt, hz.fwd_E_rs, hz.fwd_E_rt} !== 8'h00) begin
            failures++;
            $display("FAIL reset_fwd got=%h exp=00", {hz.fwd_D_rs, hz.fwd_D_rt, hz.fwd_E_rs, hz.fwd_E_rt});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({hz.stall, hz.md_busy, hz.fwd_D_rs, hz.fwd_E_rs} !== 6'b0) begin
            failures++;
            $display("FAIL post_reset got=%b exp=0", {hz.stall, hz.md_busy, hz.fwd_D_rs, hz.fwd_E_rs});
        end
    endtask

    // lw $1 (Tnew 2) then add rs=$1 Tuse 1: one bubble, then the value comes from W by the time add is in E
    task automatic test_load_use();
        flush();
        set_d(5'd5, 5'd0, 2'd1, 2'b11, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hz.stall !== 1'b0) begin failures++; $display("FAIL lu_lw_in_d got=%b exp=0", hz.stall); end
        tick();
        set_d(5'd1, 5'd6, 2'd1, 2'd1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({hz.stall, hz.E_bubble} !== 2'b11) begin
            failures++; $display("FAIL lu_stall got=%b exp=11", {hz.stall, hz.E_bubble});
        end
        tick();
        checks++;
        if (hz.stall !== 1'b0) begin failures++; $display("FAIL lu_stall_len got=%b exp=0", hz.stall); end
        checks++;
        if (hz.fwd_D_rs !== 2'd0) begin failures++; $display("FAIL lu_fwd_D_rs got=%0d exp=0", hz.fwd_D_rs); end
        tick();
        nop();
        checks++;
        if (hz.fwd_E_rs !== 2'd1) begin failures++; $display("FAIL lu_fwd_E_rs got=%0d exp=1", hz.fwd_E_rs); end
        checks++;
        if (hz.fwd_E_rt !== 2'd0) begin failures++; $display("FAIL lu_fwd_E_rt got=%0d exp=0", hz.fwd_E_rt); end
    endtask

    task automatic test_branch();
        flush();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd2, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hz.stall !== 1'b1) begin failures++; $display("FAIL br_stall got=%b exp=1", hz.stall); end
        tick();
        checks++;
        if (hz.stall !== 1'b0) begin failures++; $display("FAIL br_release got=%b exp=0", hz.stall); end
        checks++;
        if (hz.fwd_D_rs !== 2'd2) begin failures++; $display("FAIL br_fwd_D_rs got=%0d exp=2", hz.fwd_D_rs); end
    endtask

    task automatic test_jal_jr();
        flush();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd31, 5'd0, 2'd0, 2'b11, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hz.stall !== 1'b0) begin failures++; $display("FAIL jr_stall got=%b exp=0", hz.stall); end
        checks++;
        if (hz.fwd_D_rs !== 2'd3) begin failures++; $display("FAIL jr_fwd_D_rs got=%0d exp=3", hz.fwd_D_rs); end
    endtask

    task automatic test_zero_reg();
        flush();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({hz.stall, hz.fwd_D_rs, hz.fwd_D_rt} !== 5'b0) begin
            failures++; $display("FAIL zero_reg got=%b exp=0", {hz.stall, hz.fwd_D_rs, hz.fwd_D_rt});
        end
    endtask

    task automatic test_rt_hazard();
        flush();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd8, 2'b11, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hz.stall !== 1'b1) begin failures++; $display("FAIL rt_stall got=%b exp=1", hz.stall); end
        tick();
        checks++;
        if (hz.stall !== 1'b0) begin failures++; $display("FAIL rt_release got=%b exp=0", hz.stall); end
        // ALU result consumed late (Tuse 2): no stall, forwarded from M in E
        flush();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd4, 2'b11, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({hz.stall, hz.fwd_D_rt} !== 3'b000) begin
            failures++; $display("FAIL rt_late got=%b exp=000", {hz.stall, hz.fwd_D_rt});
        end
        tick();
        nop();
        checks++;
        if (hz.fwd_E_rt !== 2'd2) begin failures++; $display("FAIL rt_fwd_E_rt got=%0d exp=2", hz.fwd_E_rt); end
    endtask

    task automatic test_back_to_back();
        flush();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd9, 5'd0, 2'd1, 2'b11, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({hz.stall, hz.fwd_D_rs} !== 3'b011) begin
            failures++; $display("FAIL b2b_E_prio got=%b exp=011", {hz.stall, hz.fwd_D_rs});
        end
        tick();
        set_d(5'd9, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({hz.stall, hz.fwd_D_rs, hz.fwd_D_rt} !== 5'b01010) begin
            failures++; $display("FAIL b2b_M_prio got=%b exp=01010", {hz.stall, hz.fwd_D_rs, hz.fwd_D_rt});
        end
        checks++;
        if (hz.fwd_E_rs !== 2'd2) begin failures++; $display("FAIL b2b_fwd_E_rs got=%0d exp=2", hz.fwd_E_rs); end
        tick();
        nop();
        checks++;
        if ({hz.fwd_E_rs, hz.fwd_E_rt} !== 4'b0101) begin
            failures++; $display("FAIL b2b_fwd_E_W got=%b exp=0101", {hz.fwd_E_rs, hz.fwd_E_rt});
        end
    endtask

    // mult/div then mflo: stall covers E, M, then every busy cycle
    task automatic test_md(input logic is_div, input int exp_stall, input int exp_busy);
        int n_stall;
        int n_busy;
        n_stall = 0;
        n_busy  = 0;
        flush();
        set_d(5'd10, 5'd11, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, is_div, 1'b1);
        checks++;
        if (hz.stall !== 1'b0) begin failures++; $display("FAIL md_start_stall got=%b exp=0", hz.stall); end
        tick();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (!hz.stall) break;
            n_stall++;
            if (hz.md_busy) n_busy++;
            tick();
        end
        checks++;
        if (n_stall !== exp_stall) begin
            failures++; $display("FAIL md_stall_cycles div=%0d got=%0d exp=%0d", is_div, n_stall, exp_stall);
        end
        checks++;
        if (n_busy !== exp_busy) begin
            failures++; $display("FAIL md_busy_cycles div=%0d got=%0d exp=%0d", is_div, n_busy, exp_busy);
        end
        checks++;
        if (hz.md_busy !== 1'b0) begin failures++; $display("FAIL md_busy_end got=%b exp=0", hz.md_busy); end
    endtask

    task automatic test_reset_mid();
        flush();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 2'b11, 2'b11, 5'd12, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        repeat (3) tick();
        checks++;
        if (hz.md_busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", hz.md_busy); end
        set_d(5'd12, 5'd12, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        checks++;
        if ({hz.md_busy, hz.stall} !== 2'b00) begin
            failures++; $display("FAIL rst_mid_ctrl got=%b exp=00", {hz.md_busy, hz.stall});
        end
        checks++;
        if ({hz.fwd_D_rs, hz.fwd_D_rt, hz.fwd_E_rs, hz.fwd_E_rt} !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_fwd got=%h exp=00", {hz.fwd_D_rs, hz.fwd_D_rt, hz.fwd_E_rs, hz.fwd_E_rt});
        end
        reset = 1'b0;
        nop();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_jal_jr();
        test_zero_reg();
        test_rt_hazard();
        test_back_to_back();
        test_md(1'b0, 7, 5);
        test_md(1'b1, 12, 10);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
